// File: rtl/ita_regfile_access_ctrl.sv
// rtl/ita_regfile_access_ctrl.sv - zero-init sweep, write arbitration and read hazard control for the latch register file
// Optional feature: define ITA_RF_CTRL_FWD_EN to forward colliding write segments instead of stalling the read.
module ita_regfile_access_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_EN       = 4,
  parameter int N_WR       = 2,
  parameter int N_READ     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic                                   init_done_o,
  input  logic [N_WR-1:0]                        wr_valid_i,
  output logic [N_WR-1:0]                        wr_ready_o,
  input  logic [N_WR-1:0][ADDR_WIDTH-1:0]        wr_addr_i,
  input  logic [N_WR-1:0][DATA_WIDTH-1:0]        wr_data_i,
  input  logic [N_WR-1:0][N_EN-1:0]              wr_sel_i,
  input  logic [N_READ-1:0]                      rd_valid_i,
  output logic [N_READ-1:0]                      rd_ready_o,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]      rd_addr_i,
  output logic [N_READ-1:0]                      rd_rvalid_o,
  output logic [N_READ-1:0][DATA_WIDTH-1:0]      rd_rdata_o,
  output logic                                   rf_we_o,
  output logic [ADDR_WIDTH-1:0]                  rf_waddr_o,
  output logic [DATA_WIDTH-1:0]                  rf_wdata_o,
  output logic [N_EN-1:0]                        rf_wsel_o,
  output logic [N_READ-1:0]                      rf_re_o,
  output logic [N_READ-1:0][ADDR_WIDTH-1:0]      rf_raddr_o,
  input  logic [N_READ-1:0][DATA_WIDTH-1:0]      rf_rdata_i
);

  localparam int PTR_W = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [N_READ-1:0]       rvalid_q;

  logic                    grant;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W:0]          cand_sum;
  logic [PTR_W-1:0]        cand;
  logic [PTR_W:0]          next_sum;
  logic [N_READ-1:0]       hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      rvalid_q <= rf_re_o;
    end
  end

  // Round-robin search starting at the pointer; the extra sum bit keeps the wrap exact for any N_WR.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    if (state_q == ST_RUN) begin
      for (int i = 0; i < N_WR; i++) begin
        cand_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
        if (cand_sum >= (PTR_W+1)'(N_WR)) cand_sum = cand_sum - (PTR_W+1)'(N_WR);
        cand = cand_sum[PTR_W-1:0];
        if (!grant && wr_valid_i[cand]) begin
          grant     = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    next_sum    = '0;
    init_done_o = 1'b0;
    wr_ready_o  = '0;
    rd_ready_o  = '0;
    rf_we_o     = 1'b0;
    rf_waddr_o  = '0;
    rf_wdata_o  = '0;
    rf_wsel_o   = '0;
    rf_re_o     = '0;
    rf_raddr_o  = '0;
    hazard      = '0;
    unique case (state_q)
      ST_INIT: begin
        // Latches have no reset, so every word is written with zeros once.
        rf_we_o    = 1'b1;
        rf_waddr_o = cnt_q;
        rf_wsel_o  = '1;
        cnt_d      = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        init_done_o = 1'b1;
        if (grant) begin
          wr_ready_o[grant_idx] = 1'b1;
          rf_we_o    = 1'b1;
          rf_waddr_o = wr_addr_i[grant_idx];
          rf_wdata_o = wr_data_i[grant_idx];
          rf_wsel_o  = wr_sel_i[grant_idx];
          next_sum   = {1'b0, grant_idx} + (PTR_W+1)'(1);
          ptr_d      = (next_sum >= (PTR_W+1)'(N_WR)) ? '0 : next_sum[PTR_W-1:0];
        end
        for (int p = 0; p < N_READ; p++) begin
          hazard[p] = grant && (rf_waddr_o == rd_addr_i[p]) && (rf_wsel_o != '0);
`ifdef ITA_RF_CTRL_FWD_EN
          rd_ready_o[p] = 1'b1;
`else
          rd_ready_o[p] = !hazard[p];
`endif
          rf_re_o[p]    = rd_valid_i[p] & rd_ready_o[p];
          rf_raddr_o[p] = rd_addr_i[p];
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign rd_rvalid_o = rvalid_q;

`ifdef ITA_RF_CTRL_FWD_EN
  localparam int SEG_W = DATA_WIDTH / N_EN;

  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [N_EN-1:0]       fwd_sel_q;
  logic [N_READ-1:0]     fwd_flag_q;

  // The register file returns the pre-write word for a colliding read; patch in the written segments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_data_q <= '0;
      fwd_sel_q  <= '0;
      fwd_flag_q <= '0;
    end else begin
      fwd_data_q <= rf_wdata_o;
      fwd_sel_q  <= rf_wsel_o;
      fwd_flag_q <= rf_re_o & hazard;
    end
  end

  always_comb begin
    rd_rdata_o = rf_rdata_i;
    for (int p = 0; p < N_READ; p++) begin
      for (int s = 0; s < N_EN; s++) begin
        if (fwd_flag_q[p] && fwd_sel_q[s]) begin
          rd_rdata_o[p][s*SEG_W +: SEG_W] = fwd_data_q[s*SEG_W +: SEG_W];
        end
      end
    end
  end
`else
  assign rd_rdata_o = rf_rdata_i;
`endif

endmodule

// File: tb/tb_ita_regfile_access_ctrl.sv
// tb/tb_ita_regfile_access_ctrl.sv - directed and randomized checks of ita_regfile_access_ctrl against a behavioural model
`timescale 1ns/1ps
module tb_ita_regfile_access_ctrl;
  localparam int AW = 5, DW = 32, NE = 4, NW = 2, NR = 2, NWORDS = 32, SW = DW / NE;
`ifdef ITA_RF_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic                     init_done_o;
  logic [NW-1:0]            wr_valid_i, wr_ready_o;
  logic [NW-1:0][AW-1:0]    wr_addr_i;
  logic [NW-1:0][DW-1:0]    wr_data_i;
  logic [NW-1:0][NE-1:0]    wr_sel_i;
  logic [NR-1:0]            rd_valid_i, rd_ready_o, rd_rvalid_o;
  logic [NR-1:0][AW-1:0]    rd_addr_i;
  logic [NR-1:0][DW-1:0]    rd_rdata_o;
  logic                     rf_we_o;
  logic [AW-1:0]            rf_waddr_o;
  logic [DW-1:0]            rf_wdata_o;
  logic [NE-1:0]            rf_wsel_o;
  logic [NR-1:0]            rf_re_o;
  logic [NR-1:0][AW-1:0]    rf_raddr_o;
  logic [NR-1:0][DW-1:0]    rf_rdata_i;

  always #5 clk = ~clk;

  ita_regfile_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_EN(NE), .N_WR(NW), .N_READ(NR)) dut (
    .clk(clk), .rst(rst), .init_done_o(init_done_o),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_sel_i(wr_sel_i),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_addr_i(rd_addr_i),
    .rd_rvalid_o(rd_rvalid_o), .rd_rdata_o(rd_rdata_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_wsel_o(rf_wsel_o),
    .rf_re_o(rf_re_o), .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i)
  );

  // Register file stand-in: powers up with garbage, read data appears the cycle after the address.
  logic [DW-1:0]         emu [NWORDS];
  logic [NR-1:0][DW-1:0] emu_rdata;
  logic                  emu_filled = 1'b0;
  always @(posedge clk) begin
    if (!emu_filled) begin
      for (int i = 0; i < NWORDS; i++) emu[i] <= $urandom;
      emu_filled <= 1'b1;
    end
    for (int p = 0; p < NR; p++) if (rf_re_o[p]) emu_rdata[p] <= emu[rf_raddr_o[p]];
    if (rf_we_o) for (int s = 0; s < NE; s++)
      if (rf_wsel_o[s]) emu[rf_waddr_o][s*SW +: SW] <= rf_wdata_o[s*SW +: SW];
  end
  assign rf_rdata_i = emu_rdata;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0]         ref_mem [NWORDS];
  int                    m_ptr;
  logic [NW-1:0]         obs_grant;
  logic [AW-1:0]         obs_waddr;
  logic [NR-1:0]         obs_rd_ready;
  logic [NW-1:0][AW-1:0] r_wa;
  logic [NW-1:0][DW-1:0] r_wd;
  logic [NW-1:0][NE-1:0] r_ws;
  logic [NR-1:0][AW-1:0] r_ra;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;
    m_ptr = 0;
  endtask

  // One RUN cycle: drive requests, check combinational outputs against the model, then the responses.
  task automatic step(input logic [NW-1:0] wv, input logic [NW-1:0][AW-1:0] wa,
                      input logic [NW-1:0][DW-1:0] wd, input logic [NW-1:0][NE-1:0] ws,
                      input logic [NR-1:0] rv, input logic [NR-1:0][AW-1:0] ra);
    int g;
    logic [NW-1:0]         exp_gnt;
    logic [NR-1:0]         exp_rdy, exp_rv;
    logic [NR-1:0][DW-1:0] exp_rd;
    wr_valid_i = wv; wr_addr_i = wa; wr_data_i = wd; wr_sel_i = ws;
    rd_valid_i = rv; rd_addr_i = ra;
    #1;
    g = -1;
    for (int i = 0; i < NW; i++) if (g < 0 && wv[(m_ptr + i) % NW]) g = (m_ptr + i) % NW;
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    obs_grant = wr_ready_o;
    obs_waddr = rf_waddr_o;
    obs_rd_ready = rd_ready_o;
    check("wr_ready", wr_ready_o, exp_gnt);
    check("rf_we", rf_we_o, g >= 0);
    if (g >= 0) check("rf_write", {rf_waddr_o, rf_wsel_o, rf_wdata_o}, {wa[g], ws[g], wd[g]});
    for (int p = 0; p < NR; p++)
      exp_rdy[p] = FWD || !(g >= 0 && wa[g] == ra[p] && ws[g] != '0);
    check("rd_ready", rd_ready_o, exp_rdy);
    check("rf_re", rf_re_o, rv & exp_rdy);
    if (g >= 0) begin
      for (int s = 0; s < NE; s++) if (ws[g][s]) ref_mem[wa[g]][s*SW +: SW] = wd[g][s*SW +: SW];
      m_ptr = (g + 1) % NW;
    end
    for (int p = 0; p < NR; p++) begin
      exp_rv[p] = rv[p] & exp_rdy[p];
      exp_rd[p] = ref_mem[ra[p]];
      if (exp_rv[p]) check("rf_raddr", rf_raddr_o[p], ra[p]);
    end
    cyc();
    wr_valid_i = '0;
    rd_valid_i = '0;
    check("rd_rvalid", rd_rvalid_o, exp_rv);
    for (int p = 0; p < NR; p++) if (exp_rv[p]) check("rd_rdata", rd_rdata_o[p], exp_rd[p]);
  endtask

  // Releases reset and follows the zero sweep; stop_at >= 0 re-asserts reset at that sweep address.
  task automatic sweep(input int stop_at);
    rst = 1'b0;
    wr_valid_i = '1;
    rd_valid_i = '1;
    for (int k = 0; k < NWORDS; k++) begin
      #1;
      check("sweep_wr", {rf_we_o, rf_wsel_o, rf_wdata_o, rf_waddr_o}, {1'b1, 4'hF, 32'h0, 5'(k)});
      check("sweep_gated", {init_done_o, wr_ready_o, rd_ready_o, rf_re_o}, '0);
      if (k == stop_at) begin
        rst = 1'b1;
        wr_valid_i = '0;
        rd_valid_i = '0;
        return;
      end
      cyc();
    end
    wr_valid_i = '0;
    rd_valid_i = '0;
    #1;
    check("init_done", init_done_o, 1'b1);
    model_clear();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_valid_i = '0; wr_addr_i = '0; wr_data_i = '0; wr_sel_i = '0;
    rd_valid_i = '0; rd_addr_i = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_init_done", init_done_o, 1'b0);
    check("rst_handshake", {wr_ready_o, rd_ready_o, rd_rvalid_o}, '0);
    check("rst_sweep_start", {rf_we_o, rf_waddr_o}, {1'b1, 5'd0});

    sweep(-1);
    for (int a = 0; a < NWORDS; a++) step('0, '0, '0, '0, 2'b11, {5'(NWORDS - 1 - a), 5'(a)});

    for (int i = 0; i < 4; i++) begin
      step(2'b11, {5'd7, 5'd3}, {$urandom, $urandom}, {4'hF, 4'hF}, '0, '0);
      check("arb_alternate", obs_grant, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("arb_waddr", obs_waddr, (i % 2 == 0) ? 5'd3 : 5'd7);
    end
    for (int i = 0; i < 3; i++) begin
      step(2'b10, {5'd7, 5'd3}, {$urandom, $urandom}, {4'hF, 4'hF}, '0, '0);
      check("arb_single", obs_grant, 2'b10);
    end

    step(2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, {4'h0, 4'hF}, '0, '0);
    step('0, '0, '0, '0, 2'b01, {5'd0, 5'd5});
    check("wr_rd_rvalid", rd_rvalid_o[0], 1'b1);
    check("wr_rd_data", rd_rdata_o[0], 32'hDEADBEEF);

    step(2'b01, {5'd0, 5'd9}, {32'h0, 32'hAABBCCDD}, {4'h0, 4'hF}, '0, '0);
    step(2'b01, {5'd0, 5'd9}, {32'h0, 32'h11223344}, {4'h0, 4'b0011}, 2'b01, {5'd0, 5'd9});
    check("hazard_ready", obs_rd_ready[0], FWD);
`ifdef ITA_RF_CTRL_FWD_EN
    check("fwd_rvalid", rd_rvalid_o[0], 1'b1);
    check("fwd_data", rd_rdata_o[0], 32'hAABB3344);
`else
    check("stall_rvalid", rd_rvalid_o[0], 1'b0);
    step('0, '0, '0, '0, 2'b01, {5'd0, 5'd9});
    check("stall_rvalid_retry", rd_rvalid_o[0], 1'b1);
    check("stall_data", rd_rdata_o[0], 32'hAABB3344);
`endif

    step(2'b01, {5'd0, 5'd2}, {32'h0, 32'h0BADF00D}, {4'h0, 4'hF}, '0, '0);
    step(2'b01, {5'd0, 5'd4}, {32'h0, $urandom}, {4'h0, 4'hF}, 2'b11, {5'd2, 5'd2});
    check("dual_ready", obs_rd_ready, 2'b11);
    check("dual_rvalid", rd_rvalid_o, 2'b11);
    check("dual_data0", rd_rdata_o[0], 32'h0BADF00D);
    check("dual_data1", rd_rdata_o[1], 32'h0BADF00D);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NW; i++) begin
        r_wa[i] = 5'($urandom_range(0, 7));
        r_wd[i] = $urandom;
        r_ws[i] = 4'($urandom);
      end
      for (int p = 0; p < NR; p++) r_ra[p] = 5'($urandom_range(0, 7));
      step(2'($urandom), r_wa, r_wd, r_ws, 2'($urandom), r_ra);
    end

    step('0, '0, '0, '0, 2'b11, {5'd3, 5'd1});
    rst = 1'b1;
    #1;
    check("rst_drop_rvalid", rd_rvalid_o, 2'b00);
    check("rst_drop_done", init_done_o, 1'b0);
    cyc();
    check("rst_hold_addr", rf_waddr_o, 5'd0);
    sweep(10);
    #1;
    check("rst_mid_sweep", {init_done_o, rf_waddr_o}, {1'b0, 5'd0});
    cyc();
    sweep(-1);
    for (int a = 0; a < NWORDS; a++) step('0, '0, '0, '0, 2'b11, {5'(a), 5'(NWORDS - 1 - a)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
